interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter N_IRQ, default 16, number of external interrupt lines (1..16).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  core clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous active-high reset.
REQ-004 SHALL have irq_req  input  N_IRQ  level interrupt requests, bit i = line i.
REQ-005 SHALL have mie  input  32  interrupt enable mask from CSR file; bit i (i<N_IRQ) enables line i.
REQ-006 SHALL have exception  input  1  synchronous exception being trapped this cycle.
REQ-007 SHALL have mret  input  1  MRET instruction executing this cycle.
REQ-008 SHALL have stall  input  1  pipeline stalled; no trap entry/exit may complete.
REQ-009 SHALL have irq_o  output  1  interrupt trap request to CSR file (drives its trap-write op).
REQ-010 SHALL have irq_cause_o  output  32  mcause value for the taken interrupt.
REQ-011 SHALL have irq_ack_o  output  N_IRQ  one-hot acknowledge to the source of the taken line.
REQ-012 SHALL have irq_ret_o  output  1  one-cycle pulse on handler return.
REQ-013 SHALL have busy_o  output  1  high while an interrupt is in TAKE, HANDLER or RET.

Function
REQ-014 SHALL implement states IDLE, TAKE, HANDLER, RET; busy_o = (state != IDLE).
REQ-015 SHALL form pend = irq_req & mie[N_IRQ-1:0] combinationally each cycle.
REQ-016 IDLE: if pend != 0 and exception=0 and stall=0, SHALL latch idx = lowest set bit of pend and go to TAKE next cycle; else stay IDLE.
REQ-017 Exception SHALL have priority: exception=1 in IDLE blocks interrupt entry that cycle.
REQ-018 Latency: pend sampled at edge N, irq_o=1 during cycle N+1.
REQ-019 TAKE: irq_o=1; while stall=1 SHALL remain in TAKE with irq_o held high and irq_ack_o=0.
REQ-020 TAKE with stall=0: irq_ack_o = one-hot(idx) for exactly that cycle; next state HANDLER.
REQ-021 irq_cause_o SHALL equal 32'h8000_0010 + idx, updated at the edge entering TAKE, held until the next TAKE entry.
REQ-022 Dropping irq_req[idx] after entry SHALL NOT cancel TAKE; latched idx is used.
REQ-023 HANDLER: no new interrupt taken (no nesting); pend changes ignored.
REQ-024 HANDLER: mret=1 and stall=0 SHALL move to RET; mret with stall=1 ignored.
REQ-025 RET: irq_ret_o=1 for exactly one cycle; next state IDLE unconditionally.
REQ-026 mret in IDLE, TAKE or RET SHALL be ignored; irq_ret_o stays 0.
REQ-027 Earliest re-entry: a pending line may be latched in the first IDLE cycle after RET (TAKE two cycles after RET).
REQ-028 irq_o, irq_ack_o, irq_ret_o SHALL be 0 in every state except where stated above.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE; irq_o=0, irq_ack_o=0, irq_ret_o=0, busy_o=0, irq_cause_o=0, idx=0.
REQ-030 Reset in any state (incl. TAKE, HANDLER) SHALL abort with no ack or ret pulse emitted; reset has priority over all inputs.

Verification
REQ-031 mie=0x0000_0005, irq_req=0x0005 in IDLE -> irq_o high next cycle, irq_cause_o=0x8000_0010, irq_ack_o=0x0001 one cycle, then HANDLER.
REQ-032 irq_req=0x0008, mie=0 -> no irq_o for 20 cycles; set mie[3]=1 -> irq_o next cycle, irq_cause_o=0x8000_0013.
REQ-033 Enter TAKE, stall=1 for 3 cycles -> irq_o held 4 cycles, irq_ack_o=0x0008 only on final cycle.
REQ-034 In HANDLER raise irq_req=0xFFFF, pulse mret -> no re-entry during HANDLER; irq_ret_o one pulse; next TAKE with irq_cause_o=0x8000_0010.
REQ-035 exception=1 and pend!=0 same cycle -> no TAKE; exception=0 next cycle -> TAKE following cycle.
REQ-036 rst asserted in HANDLER -> IDLE, all outputs 0, later mret produces no irq_ret_o.

Source files
------------

// File: rtl/interrupt_controller.sv
// Level-sensitive interrupt controller: picks the lowest enabled pending line,
// raises a trap request, acknowledges the source and tracks handler return.
//
// state     | meaning
// ----------|----------------------------------------------------------
// S_IDLE    | no interrupt in service; watching enabled requests
// S_TAKE    | trap request raised; ack emitted on the first unstalled cycle
// S_HANDLER | handler running; no nesting, waiting for an unstalled mret
// S_RET     | one-cycle handler-return pulse, then back to idle
module interrupt_controller #(
    parameter int N_IRQ = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic [31:0]      mie,
    input  logic             exception,
    input  logic             mret,
    input  logic             stall,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             irq_ret_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAKE,
        S_HANDLER,
        S_RET
    } state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [3:0]       low_idx;
    logic [N_IRQ-1:0] pend;
    logic             unused_mie;

    // Enable bits above N_IRQ have no line to gate.
    assign unused_mie = ^mie;

    always_comb begin
        pend = irq_req & mie[N_IRQ-1:0];
    end

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        low_idx = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // The ack is the only output that must follow the current stall level.
    always_comb begin
        irq_ack_o = '0;
        if (irq_o && !stall) begin
            irq_ack_o = N_IRQ'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= 4'd0;
            irq_cause_o <= 32'd0;
            irq_o       <= 1'b0;
            irq_ret_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((pend != '0) && !exception && !stall) begin
                        state       <= S_TAKE;
                        idx         <= low_idx;
                        irq_cause_o <= 32'h8000_0010 + {28'd0, low_idx};
                        irq_o       <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                S_TAKE: begin
                    if (!stall) begin
                        state <= S_HANDLER;
                        irq_o <= 1'b0;
                    end
                end
                S_HANDLER: begin
                    if (mret && !stall) begin
                        state     <= S_RET;
                        irq_ret_o <= 1'b1;
                    end
                end
                S_RET: begin
                    state     <= S_IDLE;
                    irq_ret_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    irq_o     <= 1'b0;
                    irq_ret_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios plus randomized traffic
// checked against a behavioural model of the trap-entry/return rules.
module tb_interrupt_controller;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_req;
    logic [31:0]   mie;
    logic          exception;
    logic          mret;
    logic          stall;
    logic          irq_o;
    logic [31:0]   irq_cause_o;
    logic [N-1:0]  irq_ack_o;
    logic          irq_ret_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    // Model: 0 = idle, 1 = taking, 2 = in handler, 3 = returning
    int          m_phase = 0;
    int          m_line  = 0;
    logic [31:0] m_cause = 32'd0;

    interrupt_controller #(.N_IRQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_req    (irq_req),
        .mie        (mie),
        .exception  (exception),
        .mret       (mret),
        .stall      (stall),
        .irq_o      (irq_o),
        .irq_cause_o(irq_cause_o),
        .irq_ack_o  (irq_ack_o),
        .irq_ret_o  (irq_ret_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_ack();
        logic [N-1:0] a;
        a = '0;
        if (m_phase == 1 && !stall) a[m_line] = 1'b1;
        return a;
    endfunction

    // Advance one clock edge and apply the rules to the model with the inputs seen at that edge.
    task automatic step();
        logic [N-1:0] pend;
        int first;
        @(posedge clk);
        pend = irq_req & mie[N-1:0];
        if (rst) begin
            m_phase = 0;
            m_line  = 0;
            m_cause = 32'd0;
        end else if (m_phase == 0) begin
            first = -1;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && first < 0) first = i;
            end
            if (first >= 0 && !exception && !stall) begin
                m_phase = 1;
                m_line  = first;
                m_cause = 32'h8000_0000 + 32'd16 + 32'(first);
            end
        end else if (m_phase == 1) begin
            if (!stall) m_phase = 2;
        end else if (m_phase == 2) begin
            if (mret && !stall) m_phase = 3;
        end else begin
            m_phase = 0;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; irq_req = '0; mie = 32'd0;
        exception = 1'b0; mret = 1'b0; stall = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (irq_o !== 1'b0 || irq_ack_o !== '0 || irq_ret_o !== 1'b0 ||
            busy_o !== 1'b0 || irq_cause_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got irq=%b ack=%h ret=%b busy=%b cause=%h, want all 0",
                     irq_o, irq_ack_o, irq_ret_o, busy_o, irq_cause_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        mie = 32'h0000_0005; irq_req = 16'h0005;
        step();
        checks++;
        if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0010 || irq_ack_o !== 16'h0001) begin
            failures++;
            $display("FAIL basic_take: got irq=%b cause=%h ack=%h, want 1 80000010 0001",
                     irq_o, irq_cause_o, irq_ack_o);
        end
        step();
        checks++;
        if (irq_o !== 1'b0 || irq_ack_o !== '0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_handler: got irq=%b ack=%h busy=%b, want 0 0000 1",
                     irq_o, irq_ack_o, busy_o);
        end
        irq_req = '0; mret = 1'b1;
        step();
        mret = 1'b0;
        checks++;
        if (irq_ret_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_ret: got ret=%b, want 1", irq_ret_o);
        end
        step();
        checks++;
        if (irq_ret_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: got ret=%b busy=%b, want 0 0", irq_ret_o, busy_o);
        end
    endtask

    task automatic test_mask();
        int highs;
        do_reset();
        irq_req = 16'h0008; mie = 32'd0;
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (irq_o !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            failures++;
            $display("FAIL mask_blocks: got %0d irq cycles, want 0", highs);
        end
        mie = 32'h0000_0008;
        step();
        checks++;
        if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0013) begin
            failures++;
            $display("FAIL mask_enable: got irq=%b cause=%h, want 1 80000013", irq_o, irq_cause_o);
        end
    endtask

    task automatic test_stall();
        int highs;
        logic [N-1:0] acks [4];
        do_reset();
        irq_req = 16'h0008; mie = 32'h0000_0008;
        step();
        irq_req = '0;
        stall = 1'b1;
        highs = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) stall = 1'b0;
            #1;
            if (irq_o === 1'b1) highs++;
            acks[c] = irq_ack_o;
            step();
        end
        checks++;
        if (highs != 4) begin
            failures++;
            $display("FAIL stall_hold: got irq high %0d cycles, want 4", highs);
        end
        checks++;
        if (acks[0] !== '0 || acks[1] !== '0 || acks[2] !== '0 || acks[3] !== 16'h0008) begin
            failures++;
            $display("FAIL stall_ack: got %h %h %h %h, want 0000 0000 0000 0008",
                     acks[0], acks[1], acks[2], acks[3]);
        end
        checks++;
        if (irq_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_handler: got irq=%b busy=%b, want 0 1", irq_o, busy_o);
        end
    endtask

    task automatic test_no_nesting();
        int highs;
        int rets;
        do_reset();
        irq_req = 16'h0004; mie = 32'hFFFF_FFFF;
        step();
        step();
        irq_req = 16'hFFFF;
        highs = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (irq_o !== 1'b0 || busy_o !== 1'b1) highs++;
        end
        checks++;
        if (highs != 0) begin
            failures++;
            $display("FAIL nest_blocked: got %0d bad handler cycles, want 0", highs);
        end
        mret = 1'b1;
        step();
        mret = 1'b0;
        rets = (irq_ret_o === 1'b1) ? 1 : 0;
        step();
        if (irq_ret_o === 1'b1) rets++;
        checks++;
        if (rets != 1 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL nest_ret_pulse: got %0d ret cycles irq=%b, want 1 0", rets, irq_o);
        end
        step();
        checks++;
        if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0010 || irq_ack_o !== 16'h0001) begin
            failures++;
            $display("FAIL nest_reentry: got irq=%b cause=%h ack=%h, want 1 80000010 0001",
                     irq_o, irq_cause_o, irq_ack_o);
        end
    endtask

    task automatic test_exception();
        do_reset();
        irq_req = 16'h0040; mie = 32'h0000_0040; exception = 1'b1;
        step();
        checks++;
        if (irq_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL exc_blocks: got irq=%b busy=%b, want 0 0", irq_o, busy_o);
        end
        exception = 1'b0;
        step();
        checks++;
        if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0016) begin
            failures++;
            $display("FAIL exc_release: got irq=%b cause=%h, want 1 80000016", irq_o, irq_cause_o);
        end
    endtask

    task automatic test_reset_in_handler();
        int rets;
        do_reset();
        irq_req = 16'h0002; mie = 32'h0000_0002;
        step();
        step();
        irq_req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (irq_o !== 1'b0 || irq_ack_o !== '0 || irq_ret_o !== 1'b0 ||
            busy_o !== 1'b0 || irq_cause_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_handler: got irq=%b ack=%h ret=%b busy=%b cause=%h, want all 0",
                     irq_o, irq_ack_o, irq_ret_o, busy_o, irq_cause_o);
        end
        mret = 1'b1;
        rets = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (irq_ret_o !== 1'b0) rets++;
        end
        mret = 1'b0;
        checks++;
        if (rets != 0) begin
            failures++;
            $display("FAIL rst_mret_ignored: got %0d ret cycles, want 0", rets);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            irq_req   = N'($urandom);
            if ($urandom_range(0, 3) == 0) irq_req = '0;
            mie       = $urandom;
            exception = ($urandom_range(0, 99) < 15);
            mret      = ($urandom_range(0, 99) < 30);
            stall     = ($urandom_range(0, 99) < 25);
            #1;
            checks++;
            if (irq_o !== (m_phase == 1) || irq_ret_o !== (m_phase == 3) ||
                busy_o !== (m_phase != 0) || irq_ack_o !== exp_ack() ||
                irq_cause_o !== m_cause) begin
                failures++;
                $display("FAIL random_c%0d: got irq=%b ret=%b busy=%b ack=%h cause=%h, want %b %b %b %h %h",
                         c, irq_o, irq_ret_o, busy_o, irq_ack_o, irq_cause_o,
                         (m_phase == 1), (m_phase == 3), (m_phase != 0), exp_ack(), m_cause);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_mask();
        test_stall();
        test_no_nesting();
        test_exception();
        test_reset_in_handler();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
